// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller for the F -> DE -> MW core: stall/flush generation,
// variable-latency data-memory sequencing with timeout, operand forwarding and stall accounting.
module hazard_stall_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       raddr1_DE,
    input  logic [4:0]       raddr2_DE,
    input  logic             rs1_used,
    input  logic             rs2_used,
    input  logic [4:0]       waddr_MW,
    input  logic             regwrite_MW,
    input  logic             mem_op_MW,
    input  logic             br_taken_DE,
    input  logic             dmem_ack,
    output logic             dmem_req,
    output logic             StallF,
    output logic             StallE,
    output logic             FlushE,
    output logic             kill_MW,
    output logic             fwdA_sel,
    output logic             fwdB_sel,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

    state_t           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic req_s;
    logic stall_s;
    logic kill_s;
    logic fwd_a_s;
    logic fwd_b_s;

    // Access sequencer: next state, wait counter and per-cycle control from state + inputs.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        req_s      = 1'b0;
        stall_s    = 1'b0;
        kill_s     = 1'b0;
        case (state_q)
            IDLE: begin
                req_s = mem_op_MW;
                if (mem_op_MW && !dmem_ack) begin
                    stall_s    = 1'b1;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 8'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            MEM_WAIT: begin
                req_s = 1'b1;
                if (dmem_ack) begin
                    state_d    = IDLE;
                    wait_cnt_d = 8'd0;
                end else if (wait_cnt_q == TIMEOUT_C) begin
                    stall_s = 1'b1;
                    state_d = ERR;
                end else begin
                    stall_s    = 1'b1;
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ERR: begin
                // The abandoned op must not retire; a late ack here is ignored.
                kill_s     = 1'b1;
                mem_err_d  = 1'b1;
                state_d    = IDLE;
                wait_cnt_d = 8'd0;
            end
            default: begin
                state_d    = IDLE;
                wait_cnt_d = 8'd0;
            end
        endcase
    end

    // Saturating count of cycles in which the DE/MW register is held.
    always_comb begin
        if (stall_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Forwarding only matters for a real register write that the DE instruction reads.
    always_comb begin
        fwd_a_s = rs1_used & regwrite_MW & (waddr_MW != 5'd0) & (waddr_MW == raddr1_DE);
        fwd_b_s = rs2_used & regwrite_MW & (waddr_MW != 5'd0) & (waddr_MW == raddr2_DE);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            wait_cnt_q  <= 8'd0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Outputs are forced low while reset is asserted, independent of the clock.
    always_comb begin
        if (!rst) begin
            dmem_req = 1'b0;
            StallF   = 1'b0;
            StallE   = 1'b0;
            FlushE   = 1'b0;
            kill_MW  = 1'b0;
            fwdA_sel = 1'b0;
            fwdB_sel = 1'b0;
        end else begin
            dmem_req = req_s;
            StallF   = stall_s;
            StallE   = stall_s;
            FlushE   = br_taken_DE & ~stall_s;
            kill_MW  = kill_s;
            fwdA_sel = fwd_a_s;
            fwdB_sel = fwd_b_s;
        end
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl (instantiated with MEM_TIMEOUT=4).
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  raddr1_DE = 5'd0;
    logic [4:0]  raddr2_DE = 5'd0;
    logic        rs1_used = 1'b0;
    logic        rs2_used = 1'b0;
    logic [4:0]  waddr_MW = 5'd0;
    logic        regwrite_MW = 1'b0;
    logic        mem_op_MW = 1'b0;
    logic        br_taken_DE = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        dmem_req, StallF, StallE, FlushE, kill_MW, fwdA_sel, fwdB_sel, mem_err;
    logic [15:0] stall_cnt;

    int checks = 0;
    int failures = 0;

    hazard_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .raddr1_DE(raddr1_DE), .raddr2_DE(raddr2_DE),
        .rs1_used(rs1_used), .rs2_used(rs2_used),
        .waddr_MW(waddr_MW), .regwrite_MW(regwrite_MW),
        .mem_op_MW(mem_op_MW), .br_taken_DE(br_taken_DE), .dmem_ack(dmem_ack),
        .dmem_req(dmem_req), .StallF(StallF), .StallE(StallE), .FlushE(FlushE),
        .kill_MW(kill_MW), .fwdA_sel(fwdA_sel), .fwdB_sel(fwdB_sel),
        .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] r1, r2;
        logic       u1, u2;
        logic [4:0] wa;
        logic       rw, mop, br, ack;
        logic       e_req, e_stall, e_flush, e_kill, e_fa, e_fb;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_ctl(input string nm, input logic req, input logic stall,
                           input logic flush, input logic kill);
        check({nm, ".dmem_req"}, 32'(dmem_req), 32'(req));
        check({nm, ".StallF"},   32'(StallF),   32'(stall));
        check({nm, ".StallE"},   32'(StallE),   32'(stall));
        check({nm, ".FlushE"},   32'(FlushE),   32'(flush));
        check({nm, ".kill_MW"},  32'(kill_MW),  32'(kill));
    endtask

    // Apply memory/branch inputs at the falling edge and let them settle.
    task automatic drive(input logic mop, input logic ack, input logic br);
        @(negedge clk);
        mem_op_MW   = mop;
        dmem_ack    = ack;
        br_taken_DE = br;
        #1;
    endtask

    initial begin
        int stalls;
        logic seen_kill;

        //                r1     r2     u1    u2    wa     rw    mop   br    ack   req   stl   fl    kil   fa    fb
        vecs[0] = '{5'd3,  5'd7,  1'b1, 1'b1, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{5'd0,  5'd0,  1'b1, 1'b1, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{5'd5,  5'd5,  1'b0, 1'b1, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{5'd5,  5'd5,  1'b1, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{5'd9,  5'd9,  1'b1, 1'b1, 5'd9,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{5'd1,  5'd2,  1'b1, 1'b1, 5'd4,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{5'd1,  5'd2,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{5'd1,  5'd2,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{5'd31, 5'd2,  1'b1, 1'b0, 5'd31, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset state: outputs low even with hazard-triggering inputs.
        mem_op_MW = 1'b1; br_taken_DE = 1'b1; regwrite_MW = 1'b1;
        waddr_MW = 5'd6; raddr1_DE = 5'd6; rs1_used = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset.fwdA_sel", 32'(fwdA_sel), 32'd0);
        check("reset.mem_err", 32'(mem_err), 32'd0);
        check("reset.stall_cnt", 32'(stall_cnt), 32'd0);
        @(negedge clk);
        mem_op_MW = 1'b0; br_taken_DE = 1'b0; regwrite_MW = 1'b0; rs1_used = 1'b0;
        rst = 1'b1;

        // Table: forwarding, flush, zero-wait accesses, all from IDLE.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            raddr1_DE = vecs[i].r1; raddr2_DE = vecs[i].r2;
            rs1_used = vecs[i].u1;  rs2_used = vecs[i].u2;
            waddr_MW = vecs[i].wa;  regwrite_MW = vecs[i].rw;
            mem_op_MW = vecs[i].mop; br_taken_DE = vecs[i].br; dmem_ack = vecs[i].ack;
            #1;
            chk_ctl($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_stall,
                    vecs[i].e_flush, vecs[i].e_kill);
            check($sformatf("vec%0d.fwdA_sel", i), 32'(fwdA_sel), 32'(vecs[i].e_fa));
            check($sformatf("vec%0d.fwdB_sel", i), 32'(fwdB_sel), 32'(vecs[i].e_fb));
        end
        rs1_used = 1'b0; rs2_used = 1'b0; regwrite_MW = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        check("zero_wait.stall_cnt", 32'(stall_cnt), 32'd0);

        // Load acked on the 4th request cycle.
        drive(1'b1, 1'b0, 1'b0); chk_ctl("ack4.c1", 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0); chk_ctl("ack4.c2", 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0); chk_ctl("ack4.c3", 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0); chk_ctl("ack4.c4", 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0); chk_ctl("ack4.idle", 1'b0, 1'b0, 1'b0, 1'b0);
        check("ack4.stall_cnt", 32'(stall_cnt), 32'd3);

        // Taken branch held in DE across a 2-cycle wait: flush only on release.
        drive(1'b1, 1'b0, 1'b1); chk_ctl("br.c1", 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1); chk_ctl("br.c2", 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1); chk_ctl("br.release", 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0); chk_ctl("br.after", 1'b0, 1'b0, 1'b0, 1'b0);
        check("br.stall_cnt", 32'(stall_cnt), 32'd5);

        // Timeout: IDLE + wait counts 1..4 stall, then one ERR cycle (late ack ignored).
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            chk_ctl($sformatf("tmo.c%0d", i + 1), 1'b1, 1'b1, 1'b0, 1'b0);
        end
        drive(1'b1, 1'b1, 1'b0); chk_ctl("tmo.err", 1'b0, 1'b0, 1'b0, 1'b1);
        check("tmo.err.mem_err", 32'(mem_err), 32'd0);
        drive(1'b0, 1'b0, 1'b0); chk_ctl("tmo.idle", 1'b0, 1'b0, 1'b0, 1'b0);
        check("tmo.mem_err", 32'(mem_err), 32'd1);
        check("tmo.stall_cnt", 32'(stall_cnt), 32'd10);

        // Back-to-back accesses without an idle cycle; mem_err stays set.
        drive(1'b1, 1'b0, 1'b0); chk_ctl("b2b.a1", 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0); chk_ctl("b2b.a2", 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0); chk_ctl("b2b.b1", 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0); chk_ctl("b2b.b2", 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        check("b2b.stall_cnt", 32'(stall_cnt), 32'd12);
        check("b2b.mem_err_sticky", 32'(mem_err), 32'd1);

        // Reset asserted mid-wait at count 2: asynchronous clear of everything.
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        regwrite_MW = 1'b1; waddr_MW = 5'd7; raddr1_DE = 5'd7; rs1_used = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk_ctl("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_mid.fwdA_sel", 32'(fwdA_sel), 32'd0);
        check("rst_mid.mem_err", 32'(mem_err), 32'd0);
        check("rst_mid.stall_cnt", 32'(stall_cnt), 32'd0);
        @(negedge clk);
        rs1_used = 1'b0; regwrite_MW = 1'b0; mem_op_MW = 1'b0;
        rst = 1'b1;

        // Fresh load after reset restarts the wait count from 1: 5 stalls before ERR.
        stalls = 0;
        seen_kill = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!seen_kill) begin
                drive(1'b1, 1'b0, 1'b0);
                if (kill_MW) seen_kill = 1'b1;
                else if (StallE) stalls++;
            end
        end
        check("restart.err_reached", 32'(seen_kill), 32'd1);
        check("restart.stalls", 32'(stalls), 32'd5);
        drive(1'b0, 1'b0, 1'b0);
        check("restart.mem_err", 32'(mem_err), 32'd1);
        check("restart.stall_cnt", 32'(stall_cnt), 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
